check_frame_serializer: RTL and testbench
=========================================

Name: check_frame_serializer

Overview:
- Downstream consumer of the byte-stream checker's result outputs (check1, check2, checkData[63:0]).
- Detects each new nonzero check result and queues a snapshot of it in a small FIFO.
- Emits each snapshot as a 9-byte frame over a byte-wide valid/ready stream for a logger/UART stage.
- Counts results lost to FIFO overflow.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- HDR_TAG, 4'hA, upper nibble of every frame header byte.

Ports:
- clock  input  1  sole clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- check1  input  1  checker flag 1.
- check2  input  1  checker flag 2.
- checkData  input  64  checker result word.
- outData  output  8  frame byte.
- outValid  output  1  outData valid.
- outReady  input  1  downstream accepts a byte when high with outValid.
- dropCount  output  8  saturating count of discarded snapshots.
- busy  output  1  FIFO non-empty or frame in flight.

Behaviour:
- Reset: clear is asynchronous and active-high. It forces outData=0, outValid=0, dropCount=0 and busy=0. It empties the FIFO, sets the serializer to IDLE and sets the last-sample register to 0. A clear mid-frame abandons that frame; nothing resumes after clear deasserts.
- Sample vector: S = {check1, check2, checkData}, 66 bits, registered every cycle into last.
- Capture strobe: cap = (check1|check2) && (S != last). Repeated identical results are captured once. A flags=00 cycle followed by the same result re-arms capture.
- Write path:
  - cap with FIFO not full: the entry is written at that edge.
  - cap with FIFO full and no pop on the same edge: the entry is dropped and dropCount increments, saturating at 8'hFF.
  - cap with FIFO full and a pop on the same edge: the write is accepted; full is evaluated after the pop.
- Serializer FSM states: IDLE, HDR, DAT.
  - IDLE -> HDR: FIFO non-empty. Pop the head entry into a 66-bit frame register. outValid=1, outData = {HDR_TAG, 2'b00, c1, c2}.
  - HDR -> DAT: on accept (outValid && outReady). Set idx=0 and outData = frame[63:56].
  - DAT: on accept with idx<7, increment idx; outData = next byte, MSB first.
  - DAT with idx==7 on accept: if the FIFO is non-empty, pop and go directly to HDR with no bubble; else go to IDLE with outValid=0.
- Stream rules:
  - outData is stable while outValid && !outReady.
  - outValid never drops without an accept.
  - outValid never depends combinationally on outReady.
- Latency: with the FIFO empty and IDLE, a cap at edge N gives outValid=1 with the header after edge N+1. Best-case frame length is 9 cycles; back-to-back frames are 9 cycles apart.
- A FIFO entry written at edge N is not poppable until edge N+1 (no write-through).
- busy = FIFO non-empty || state != IDLE.
- All outputs are registered.

Decomposition:
- Shared package check_frame_pkg holds:
  - the 66-bit snapshot typedef {c1, c2, data};
  - the FSM state enum;
  - the frame-length constant 9;
  - the header-byte builder function.
- One sub-module: snapshot_fifo. It is a synchronous FIFO, parameterised on width and DEPTH, with full/empty flags and registered storage, and same-edge push/pop allowed.

Test Plan:
- Reset then idle: clear=1 for 3 cycles, flags 00 → outValid=0, dropCount=0, busy=0 throughout.
- Single frame:
  - Stimulus: check1=1, check2=0, checkData=64'h0123_4567_89AB_CDEF held, outReady=1.
  - Required: exactly one frame, bytes A2,01,23,45,67,89,AB,CD,EF on consecutive cycles, header one cycle after capture. A held identical value produces no second frame.
- Backpressure: same stimulus, outReady toggling 1,0,0,1,… → byte order unchanged and outData stable during every stall.
- Overflow:
  - Stimulus: outReady=0; present 6 distinct results with flags 11 and checkData=1..6 (DEPTH=4).
  - Required: 4 entries queued and dropCount=1. The first is popped into the frame register, so the FIFO holds 2..5 and 6 is dropped.
  - Then outReady=1: frames carry data 1,2,3,4,5 with headers A3, and the frames are back-to-back.
- Re-arm: result X, then flags 00 for one cycle, then X again → two identical frames.
- Mid-frame clear: assert clear after byte 4 of a frame → outValid falls immediately (asynchronously), no residual bytes afterward, dropCount=0, next capture produces a complete fresh frame.

Source files
------------

// File: rtl/check_frame_pkg.sv
// Shared types and helpers for the check-result frame serializer.
package check_frame_pkg;

  localparam int unsigned SNAP_W    = 66;
  localparam int unsigned FRAME_LEN = 9;

  // One captured checker result: both flags plus the 64-bit word.
  typedef struct packed {
    logic        c1;
    logic        c2;
    logic [63:0] data;
  } snapshot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DAT  = 2'd2
  } ser_state_t;

  // Header byte: tag nibble, two zero bits, then the two flags.
  function automatic logic [7:0] hdr_byte(input logic [3:0] tag,
                                          input logic       c1,
                                          input logic       c2);
    return {tag, 2'b00, c1, c2};
  endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// Synchronous FIFO with same-edge push/pop; head is read combinationally
// from registered storage, so a write becomes visible one edge later.
module snapshot_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage write; no reset needed on the data array.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/check_frame_serializer.sv
// Captures each new nonzero checker result into a FIFO and streams every
// snapshot out as a 9-byte frame (header + 8 data bytes, MSB first).
module check_frame_serializer
  import check_frame_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        check1,
  input  logic        check2,
  input  logic [63:0] checkData,
  output logic [7:0]  outData,
  output logic        outValid,
  input  logic        outReady,
  output logic [7:0]  dropCount,
  output logic        busy
);

  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 2);

  snapshot_t        w_sample;
  snapshot_t        w_head;
  snapshot_t        r_last;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_next;
  logic             w_cap;
  logic             w_accept;
  logic             w_last_byte;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_to_idle;

  ser_state_t       r_state;
  logic [63:0]      r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic [7:0]       r_drop;
  logic             r_busy;

  assign w_sample    = {check1, check2, checkData};
  assign w_cap       = (check1 | check2) && (w_sample != r_last);
  assign w_accept    = r_out_valid && outReady;
  assign w_last_byte = (r_state == ST_DAT) && (r_idx == LAST_IDX);
  // Pop when idle, or on the final data byte so the next header follows without a bubble.
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || (w_accept && w_last_byte));
  assign w_push      = w_cap && (!w_full || w_pop);
  assign w_drop      = w_cap && w_full && !w_pop;
  assign w_to_idle   = w_empty && ((r_state == ST_IDLE) || (w_accept && w_last_byte));
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  snapshot_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .clear   (clear),
    .i_push  (w_push),
    .i_wdata (w_sample),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Previous-sample register used for change detection.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_last <= '0;
    else       r_last <= w_sample;
  end

  // Saturating overflow counter.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                          r_drop <= '0;
    else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  end

  // Busy reflects the FIFO occupancy and serializer state after this edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_busy <= 1'b0;
    else       r_busy <= (w_count_next != '0) || !w_to_idle;
  end

  // Serializer: header then eight data bytes, shifted out MSB first.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_shift     <= w_head.data;
            r_out_data  <= hdr_byte(HDR_TAG, w_head.c1, w_head.c2);
            r_out_valid <= 1'b1;
            r_state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            r_idx      <= '0;
            r_out_data <= r_shift[63:56];
            r_shift    <= {r_shift[55:0], 8'h00};
            r_state    <= ST_DAT;
          end
        end
        ST_DAT: begin
          if (w_accept) begin
            if (r_idx != LAST_IDX) begin
              r_idx      <= r_idx + IDX_W'(1);
              r_out_data <= r_shift[63:56];
              r_shift    <= {r_shift[55:0], 8'h00};
            end else if (!w_empty) begin
              r_shift     <= w_head.data;
              r_out_data  <= hdr_byte(HDR_TAG, w_head.c1, w_head.c2);
              r_state     <= ST_HDR;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign outData   = r_out_data;
  assign outValid  = r_out_valid;
  assign dropCount = r_drop;
  assign busy      = r_busy;

endmodule

// File: tb/tb_check_frame_serializer.sv
// Self-checking bench for check_frame_serializer: directed steps plus a
// random phase, all checked cycle by cycle against a queue-based model.
module tb_check_frame_serializer;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        clear;
  logic        check1;
  logic        check2;
  logic [63:0] checkData;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic [7:0]  dropCount;
  logic        busy;

  check_frame_serializer dut (
    .clock     (clock),
    .clear     (clear),
    .check1    (check1),
    .check2    (check2),
    .checkData (checkData),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .dropCount (dropCount),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: pending results, bytes of the frame on the wire, last sample, drops.
  typedef struct {
    bit          c1;
    bit          c2;
    logic [63:0] d;
  } snap_t;
  typedef logic [7:0] byteq_t[$];

  snap_t       m_fifo[$];
  logic [7:0]  m_bytes[$];
  logic [65:0] m_last;
  int          m_drop;
  logic [7:0]  obs[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  k_frame [9] = '{8'hA2, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [63:0] k_data = 64'h0123_4567_89AB_CDEF;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic byteq_t frame_bytes(input snap_t s);
    byteq_t q;
    q.push_back({4'hA, 2'b00, s.c1, s.c2});
    for (int i = 7; i >= 0; i--) q.push_back(s.d[i*8 +: 8]);
    return q;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_bytes.delete();
    m_last = '0;
    m_drop = 0;
  endtask

  task automatic model_edge();
    logic [65:0] s;
    bit          mv, acc, pop, cap;
    snap_t       sn;
    if (clear) begin
      model_reset();
      return;
    end
    s   = {check1, check2, checkData};
    mv  = m_bytes.size() > 0;
    acc = mv && outReady;
    pop = (m_fifo.size() > 0) && (!mv || (acc && m_bytes.size() == 1));
    cap = (check1 || check2) && (s !== m_last);
    if (acc) void'(m_bytes.pop_front());
    if (pop) begin
      sn = m_fifo.pop_front();
      m_bytes = frame_bytes(sn);
    end
    if (cap) begin
      if (m_fifo.size() < DEPTH) begin
        sn.c1 = check1; sn.c2 = check2; sn.d = checkData;
        m_fifo.push_back(sn);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    m_last = s;
  endtask

  task automatic check_model();
    chk("outValid", 64'(outValid), 64'(m_bytes.size() > 0));
    if (m_bytes.size() > 0) chk("outData", 64'(outData), 64'(m_bytes[0]));
    chk("dropCount", 64'(dropCount), 64'(m_drop));
    chk("busy", 64'(busy), 64'((m_fifo.size() > 0) || (m_bytes.size() > 0)));
  endtask

  // One clock: log any accepted byte, advance the model with the edge, check after it.
  task automatic cycle();
    if (outValid && outReady && !clear) obs.push_back(outData);
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_in(input logic c1, input logic c2, input logic [63:0] d);
    check1 = c1; check2 = c2; checkData = d;
  endtask

  initial begin
    logic [63:0] x2;
    clear = 1'b1; outReady = 1'b0;
    set_in(1'b0, 1'b0, 64'h0);
    model_reset();

    // Reset then idle.
    #1;
    chk("rst_valid", 64'(outValid), 64'd0);
    chk("rst_data", 64'(outData), 64'd0);
    repeat (3) cycle();
    chk("rst_drop", 64'(dropCount), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    clear = 1'b0;
    repeat (2) cycle();

    // Single frame, result held.
    obs.delete();
    outReady = 1'b1;
    set_in(1'b1, 1'b0, k_data);
    cycle();
    chk("lat_no_valid_yet", 64'(outValid), 64'd0);
    cycle();
    chk("lat_hdr_valid", 64'(outValid), 64'd1);
    chk("lat_hdr_byte", 64'(outData), 64'hA2);
    repeat (14) cycle();
    chk("single_len", 64'(obs.size()), 64'd9);
    for (int i = 0; i < 9; i++) if (i < obs.size()) chk("single_byte", 64'(obs[i]), 64'(k_frame[i]));

    // Backpressure: re-arm, then same result with ready 1,0,0,...
    set_in(1'b0, 1'b0, 64'h0);
    cycle();
    obs.delete();
    set_in(1'b1, 1'b0, k_data);
    for (int k = 0; k < 45; k++) begin
      outReady = (k % 3 == 0);
      cycle();
    end
    chk("bp_len", 64'(obs.size()), 64'd9);
    for (int i = 0; i < 9; i++) if (i < obs.size()) chk("bp_byte", 64'(obs[i]), 64'(k_frame[i]));

    // Overflow: six distinct results into a stalled stream.
    set_in(1'b0, 1'b0, 64'h0);
    outReady = 1'b1;
    repeat (4) cycle();
    outReady = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b1, 1'b1, 64'(i));
      cycle();
    end
    set_in(1'b0, 1'b0, 64'h0);
    repeat (2) cycle();
    chk("ovf_drop", 64'(dropCount), 64'd1);
    obs.delete();
    outReady = 1'b1;
    repeat (45) cycle();
    chk("ovf_len", 64'(obs.size()), 64'd45);
    for (int f = 0; f < 5; f++) begin
      if (obs.size() >= 9 * (f + 1)) begin
        chk("ovf_hdr", 64'(obs[9*f]), 64'hA3);
        for (int b = 1; b < 9; b++)
          chk("ovf_dat", 64'(obs[9*f+b]), (b == 8) ? 64'(f + 1) : 64'd0);
      end
    end
    chk("ovf_busy_end", 64'(busy), 64'd0);

    // Re-arm: X, flags 00, X again gives two identical frames.
    repeat (2) cycle();
    obs.delete();
    x2 = {$urandom, $urandom};
    set_in(1'b0, 1'b1, x2); cycle();
    set_in(1'b0, 1'b0, x2); cycle();
    set_in(1'b0, 1'b1, x2); cycle();
    set_in(1'b0, 1'b0, 64'h0);
    repeat (25) cycle();
    chk("rearm_len", 64'(obs.size()), 64'd18);
    if (obs.size() == 18) begin
      chk("rearm_hdr", 64'(obs[0]), 64'hA1);
      for (int i = 0; i < 8; i++) chk("rearm_d1", 64'(obs[1+i]), 64'(x2[(7-i)*8 +: 8]));
      for (int i = 0; i < 8; i++) chk("rearm_d2", 64'(obs[10+i]), 64'(x2[(7-i)*8 +: 8]));
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 9) < 3) set_in(1'b0, 1'b0, 64'($urandom_range(0, 3)));
        else begin
          x2 = 64'($urandom_range(1, 3));
          set_in(x2[0], x2[1], 64'($urandom_range(0, 3)) << 60 | 64'($urandom_range(0, 3)));
        end
      end
      outReady = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Mid-frame clear.
    set_in(1'b0, 1'b0, 64'h0);
    outReady = 1'b1;
    repeat (60) cycle();
    set_in(1'b1, 1'b1, 64'hFEED_FACE_CAFE_BEEF); cycle();
    set_in(1'b0, 1'b0, 64'h0);
    repeat (6) cycle();
    #2 clear = 1'b1;
    #1;
    chk("clr_valid_async", 64'(outValid), 64'd0);
    chk("clr_busy_async", 64'(busy), 64'd0);
    chk("clr_drop_async", 64'(dropCount), 64'd0);
    chk("clr_data_async", 64'(outData), 64'd0);
    model_reset();
    cycle();
    clear = 1'b0;
    obs.delete();
    repeat (12) cycle();
    chk("clr_no_residue", 64'(obs.size()), 64'd0);
    set_in(1'b1, 1'b0, k_data); cycle();
    set_in(1'b0, 1'b0, 64'h0);
    repeat (14) cycle();
    chk("clr_fresh_len", 64'(obs.size()), 64'd9);
    for (int i = 0; i < 9; i++) if (i < obs.size()) chk("clr_fresh_byte", 64'(obs[i]), 64'(k_frame[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
